ram_io_responder: RTL and testbench

Byte-wide memory/IO responder at the far end of the CPU's external memory bus. It answers the memory controller's `mem_a`/`mem_dout`/`mem_wr` requests with one-cycle-latency reads from an on-chip byte RAM, and decodes the IO window (`mem_a[17:16] == 2'b11`). In that window it feeds a TX byte queue toward the UART transmitter, optionally pops an RX byte queue, and raises the program-halt flag. It also generates the `io_buffer_full` back-pressure signal the controller consumes.

---
 rtl/ram_io_responder.sv | 164 ++++++++++++++++
 tb/tb_ram_io_responder.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/ram_io_responder.sv
// ram_io_responder: byte RAM plus IO window responder on the external memory bus.
// Reads return registered data one cycle after the request. The IO window
// (mem_a[17:16] == 2'b11) provides a TX byte queue toward the UART, a sticky
// halt flag, and the io_buffer_full back-pressure signal.
// Optional feature macro: IO_RX_EN adds the RX byte queue, the rx_* ports,
// the popping DATA read and CTRL bit 1.
module ram_io_responder #(
  parameter int ADDR_WIDTH  = 17,
  parameter int TXQ_DEPTH   = 8,
  parameter int FULL_MARGIN = 2,
  parameter int RXQ_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_overflow,
  output logic        halt
`ifdef IO_RX_EN
  ,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
`endif
);

  localparam int TXP   = $clog2(TXQ_DEPTH);
  localparam int TXC_W = TXP + 1;
  localparam logic [TXC_W-1:0] TX_CAP = TXC_W'(TXQ_DEPTH);
  localparam logic [TXC_W-1:0] TX_THR = TXC_W'(TXQ_DEPTH - FULL_MARGIN);

  logic [7:0] ram [0:(2**ADDR_WIDTH)-1];
  logic [7:0] txq [0:TXQ_DEPTH-1];

  logic             io_sel, data_sel, ctrl_sel, bus_rd, bus_wr;
  logic             tx_push_req, tx_push, tx_pop;
  logic [TXC_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [TXP-1:0]   tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic             full_q, full_d, ovf_q, ovf_d, halt_q, halt_d;
  logic [7:0]       din_q, din_d;
  logic             rx_nonempty;
  logic [7:0]       rx_head;

  // Address bits above the decoded window are ignored by design.
  logic unused_addr_hi;
  assign unused_addr_hi = ^mem_a[31:18];

  assign io_sel   = mem_a[17:16] == 2'b11;
  assign data_sel = io_sel && (mem_a[2:0] == 3'd0);
  assign ctrl_sel = io_sel && (mem_a[2:0] == 3'd4);
  assign bus_wr   = rdy && mem_wr;
  assign bus_rd   = rdy && !mem_wr;

  // A full queue still takes a push when the head leaves in the same cycle.
  assign tx_valid    = tx_cnt_q != '0;
  assign tx_data     = txq[tx_rp_q];
  assign tx_pop      = tx_valid && tx_ready;
  assign tx_push_req = bus_wr && data_sel;
  assign tx_push     = tx_push_req && ((tx_cnt_q != TX_CAP) || tx_pop);

`ifdef IO_RX_EN
  localparam int RXP   = $clog2(RXQ_DEPTH);
  localparam int RXC_W = RXP + 1;
  localparam logic [RXC_W-1:0] RX_CAP = RXC_W'(RXQ_DEPTH);

  logic [7:0]       rxq [0:RXQ_DEPTH-1];
  logic [RXC_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [RXP-1:0]   rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic             rx_push, rx_pop;

  assign rx_nonempty = rx_cnt_q != '0;
  assign rx_ready    = rx_cnt_q != RX_CAP;
  assign rx_head     = rxq[rx_rp_q];
  assign rx_push     = rx_valid && rx_ready;
  assign rx_pop      = bus_rd && data_sel && rx_nonempty;

  // RX queue pointer and occupancy next-state.
  always_comb begin
    rx_cnt_d = rx_cnt_q + RXC_W'(rx_push) - RXC_W'(rx_pop);
    rx_wp_d  = rx_wp_q + RXP'(rx_push);
    rx_rp_d  = rx_rp_q + RXP'(rx_pop);
  end

  // RX queue control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_cnt_q <= '0;
      rx_wp_q  <= '0;
      rx_rp_q  <= '0;
    end else begin
      rx_cnt_q <= rx_cnt_d;
      rx_wp_q  <= rx_wp_d;
      rx_rp_q  <= rx_rp_d;
    end
  end

  // RX byte storage; contents need no reset.
  always_ff @(posedge clk) begin
    if (rx_push) rxq[rx_wp_q] <= rx_data;
  end
`else
  logic unused_rx_cfg;
  assign unused_rx_cfg = RXQ_DEPTH > 0;
  assign rx_nonempty   = 1'b0;
  assign rx_head       = 8'h00;
`endif

  // Next-state for TX queue control, sticky flags and the read-data register.
  always_comb begin
    tx_cnt_d = tx_cnt_q + TXC_W'(tx_push) - TXC_W'(tx_pop);
    tx_wp_d  = tx_wp_q + TXP'(tx_push);
    tx_rp_d  = tx_rp_q + TXP'(tx_pop);
    full_d   = tx_cnt_d >= TX_THR;
    ovf_d    = ovf_q | (tx_push_req && !tx_push);
    halt_d   = halt_q | (bus_wr && ctrl_sel);
    din_d    = din_q;
    if (bus_rd) begin
      if (!io_sel)       din_d = ram[mem_a[ADDR_WIDTH-1:0]];
      else if (data_sel) din_d = rx_nonempty ? rx_head : 8'h00;
      else if (ctrl_sel) din_d = {6'b0, rx_nonempty, full_q};
      else               din_d = 8'h00;
    end
  end

  // Control and bus-facing registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_cnt_q <= '0;
      tx_wp_q  <= '0;
      tx_rp_q  <= '0;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
      halt_q   <= 1'b0;
      din_q    <= 8'h00;
    end else begin
      tx_cnt_q <= tx_cnt_d;
      tx_wp_q  <= tx_wp_d;
      tx_rp_q  <= tx_rp_d;
      full_q   <= full_d;
      ovf_q    <= ovf_d;
      halt_q   <= halt_d;
      din_q    <= din_d;
    end
  end

  // RAM and TX byte storage; RAM survives reset.
  always_ff @(posedge clk) begin
    if (bus_wr && !io_sel) ram[mem_a[ADDR_WIDTH-1:0]] <= mem_dout;
    if (tx_push) txq[tx_wp_q] <= mem_dout;
  end

  assign mem_din        = din_q;
  assign io_buffer_full = full_q;
  assign tx_overflow    = ovf_q;
  assign halt           = halt_q;

endmodule

// File: tb/tb_ram_io_responder.sv
// Bench for ram_io_responder: directed scenarios then randomized traffic,
// all checked against a queue-based behavioural model.
module tb_ram_io_responder;
  localparam int TXQ_DEPTH   = 8;
  localparam int FULL_MARGIN = 2;
  localparam int RXQ_DEPTH   = 4;

  logic        clk = 1'b0;
  logic        rst, rdy, mem_wr, tx_ready, tx_valid, tx_overflow, halt, io_buffer_full;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout, mem_din, tx_data;
  logic [7:0]  rx_data;
  logic        rx_valid;
`ifdef IO_RX_EN
  logic        rx_ready;
`else
  logic unused_rx;
  assign unused_rx = rx_valid ^ (^rx_data);
`endif

  always #5 clk = ~clk;

  ram_io_responder #(
    .ADDR_WIDTH(17), .TXQ_DEPTH(TXQ_DEPTH), .FULL_MARGIN(FULL_MARGIN), .RXQ_DEPTH(RXQ_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .mem_a(mem_a), .mem_dout(mem_dout), .mem_wr(mem_wr),
    .mem_din(mem_din), .io_buffer_full(io_buffer_full), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_overflow(tx_overflow), .halt(halt)
`ifdef IO_RX_EN
    , .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [7:0] m_ram [int];
  logic [7:0] m_txq [$];
  logic [7:0] m_rxq [$];
  logic [7:0] m_din;
  bit         m_full, m_ovf, m_halt;

  // Drive one request cycle, advance the model, then compare after the edge.
  task automatic step(input bit r, input bit rd, input bit wr, input logic [31:0] a,
                      input logic [7:0] d, input bit txr, input bit rxv, input logic [7:0] rxd);
    bit io, dsel, csel, pop, pre_full;
    int pre_tx, pre_rx;
    rst = r; rdy = rd; mem_wr = wr; mem_a = a; mem_dout = d; tx_ready = txr;
    rx_valid = rxv; rx_data = rxd;
    io   = a[17:16] == 2'b11;
    dsel = io && (a[2:0] == 3'd0);
    csel = io && (a[2:0] == 3'd4);
    if (r) begin
      m_txq.delete(); m_rxq.delete();
      m_din = 8'h00; m_full = 0; m_ovf = 0; m_halt = 0;
    end else begin
      pre_tx = m_txq.size(); pre_rx = m_rxq.size(); pre_full = m_full;
      pop = (pre_tx > 0) && txr;
      if (rd && !wr) begin
        if (!io)       m_din = m_ram[int'(a[16:0])];
        else if (dsel) m_din = (pre_rx > 0) ? m_rxq[0] : 8'h00;
        else if (csel) m_din = {6'b0, (pre_rx > 0), pre_full};
        else           m_din = 8'h00;
      end
      if (rd && wr && !io) m_ram[int'(a[16:0])] = d;
      if (rd && wr && csel) m_halt = 1;
      if (pop) void'(m_txq.pop_front());
      if (rd && wr && dsel) begin
        if (pre_tx < TXQ_DEPTH || pop) m_txq.push_back(d);
        else m_ovf = 1;
      end
      m_full = m_txq.size() >= TXQ_DEPTH - FULL_MARGIN;
`ifdef IO_RX_EN
      if (rd && !wr && dsel && pre_rx > 0) void'(m_rxq.pop_front());
      if (rxv && pre_rx < RXQ_DEPTH) m_rxq.push_back(rxd);
`endif
    end
    @(negedge clk);
    chk("mem_din", mem_din, m_din);
    chk("io_buffer_full", io_buffer_full, m_full);
    chk("tx_valid", tx_valid, m_txq.size() != 0);
    if (m_txq.size() != 0) chk("tx_data", tx_data, m_txq[0]);
    chk("tx_overflow", tx_overflow, m_ovf);
    chk("halt", halt, m_halt);
`ifdef IO_RX_EN
    chk("rx_ready", rx_ready, m_rxq.size() < RXQ_DEPTH);
`endif
  endtask

  task automatic idle(input bit txr);
    step(0, 1, 0, 32'h0002_0000, 8'h00, txr, 0, 8'h00);
  endtask

  initial begin
    logic [31:0] hi, a;
    logic [7:0]  d;
    int bias, sel;
    bit r, rd, wr;
    rst = 1; rdy = 1; mem_wr = 0; mem_a = '0; mem_dout = '0; tx_ready = 0;
    rx_valid = 0; rx_data = '0;
    m_din = 0; m_full = 0; m_ovf = 0; m_halt = 0;
    @(negedge clk);
    step(1, 1, 0, 32'h0, 8'h00, 0, 0, 8'h00);
    step(1, 1, 0, 32'h0, 8'h00, 0, 0, 8'h00);
    chk("rst_mem_din", mem_din, 8'h00);
    chk("rst_tx_valid", tx_valid, 1'b0);

    // Preload the RAM window used by the random phase
    for (int i = 0; i < 16; i++) step(0, 1, 1, 32'h10 + i, 8'(i * 7 + 3), 0, 0, 8'h00);

    // RAM write/read and adjacency
    step(0, 1, 1, 32'h0001_0010 & 32'h0000_0010, 8'hA5, 0, 0, 8'h00);
    step(0, 1, 0, 32'h10, 8'h00, 0, 0, 8'h00);
    chk("ram_rd", mem_din, 8'hA5);
    step(0, 1, 0, 32'h11, 8'h00, 0, 0, 8'h00);
    chk("ram_adj", mem_din, 8'(1 * 7 + 3));

    // TX ordering
    step(0, 1, 1, 32'h3_0000, 8'h41, 0, 0, 8'h00);
    step(0, 1, 1, 32'h3_0000, 8'h42, 0, 0, 8'h00);
    step(0, 1, 1, 32'h3_0000, 8'h43, 0, 0, 8'h00);
    chk("tx_head", tx_data, 8'h41);
    for (int i = 0; i < 3; i++) idle(1);
    chk("tx_drained", tx_valid, 1'b0);

    // Threshold and overflow
    for (int i = 0; i < 6; i++) step(0, 1, 1, 32'h3_0000, 8'(8'h60 + i), 0, 0, 8'h00);
    chk("full_at_6", io_buffer_full, 1'b1);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 32'h3_0000, 8'(8'h70 + i), 0, 0, 8'h00);
    chk("ovf_set", tx_overflow, 1'b1);
    for (int i = 0; i < 9; i++) idle(1);

    // rdy low freezes bus side
    step(0, 0, 1, 32'h3_0000, 8'hEE, 0, 0, 8'h00);
    step(0, 0, 1, 32'h12, 8'hEE, 0, 0, 8'h00);
    chk("rdy_no_push", tx_valid, 1'b0);
    step(0, 1, 0, 32'h12, 8'h00, 0, 0, 8'h00);
    chk("rdy_no_ram", mem_din, 8'(2 * 7 + 3));

    // Halt, then reset mid-drain
    step(0, 1, 1, 32'h3_0004, 8'h00, 0, 0, 8'h00);
    idle(0);
    chk("halt_sticky", halt, 1'b1);
    for (int i = 0; i < 7; i++) step(0, 1, 1, 32'h3_0000, 8'(i), 0, 0, 8'h00);
    idle(1);
    step(1, 1, 0, 32'h0, 8'h00, 1, 0, 8'h00);
    chk("rst_drain_valid", tx_valid, 1'b0);
    chk("rst_drain_full", io_buffer_full, 1'b0);

`ifdef IO_RX_EN
    step(0, 1, 0, 32'h2_0000, 8'h00, 0, 1, 8'h55);
    step(0, 1, 0, 32'h3_0004, 8'h00, 0, 0, 8'h00);
    chk("rx_ctrl", mem_din, 8'h02);
    step(0, 1, 0, 32'h3_0000, 8'h00, 0, 0, 8'h00);
    chk("rx_data", mem_din, 8'h55);
    step(0, 1, 0, 32'h3_0000, 8'h00, 0, 0, 8'h00);
    chk("rx_empty", mem_din, 8'h00);
`endif

    // Randomized traffic
    bias = 50;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 100 == 0) bias = (($urandom_range(0, 2) == 0) ? 5 : ($urandom_range(0, 1) == 0) ? 50 : 95);
      r  = $urandom_range(0, 299) == 0;
      rd = $urandom_range(0, 7) != 0;
      wr = !r && $urandom_range(0, 1) == 1;
      hi = $urandom();
      d  = 8'($urandom());
      sel = $urandom_range(0, 9);
      if (sel <= 4)      a = {hi[31:18], 18'h00010 + 18'($urandom_range(0, 15))};
      else if (sel <= 7) a = {hi[31:18], 18'h30000};
      else if (sel == 8) begin
        a = {hi[31:18], 18'h30004};
        if ($urandom_range(0, 19) != 0) wr = 0;
      end else           a = {hi[31:18], 18'h30000 + 18'($urandom_range(1, 3)) * 18'd2 - 18'd1};
      step(r, rd, wr, a, d, $urandom_range(0, 99) < bias, $urandom_range(0, 3) == 0, 8'($urandom()));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
